uart_frame_rx: RTL and testbench



---
 rtl/uart_frame_rx_pkg.sv | 14 +
 rtl/uart_frame_rx_gap_timer.sv | 20 ++
 rtl/uart_frame_rx.sv | 103 ++++++++++
 tb/tb_uart_frame_rx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_rx_pkg.sv
// uart_frame_pkg: shared state type, default header/frame constants and slot address helper
package uart_frame_pkg;
  typedef enum logic [1:0] {IDLE, HDR1, SLOT, PAYLOAD} state_t;
  localparam logic [7:0]  DEF_SYNC0       = 8'hA5;
  localparam logic [7:0]  DEF_SYNC1       = 8'h5A;
  localparam int unsigned DEF_FRAME_BYTES = 307200;
  localparam int unsigned DEF_NUM_SLOTS   = 4;
  localparam logic [22:0] DEF_BASE_ADDR   = 23'h100000;
  localparam int unsigned DEF_TIMEOUT_CYC = 20000;
  function automatic logic [22:0] slot_base(input logic [1:0] slot, input logic [22:0] base,
                                            input int unsigned frame_bytes);
    return base + 23'(32'(slot) * frame_bytes);
  endfunction
endpackage

// File: rtl/uart_frame_rx_gap_timer.sv
// uart_frame_rx_gap_timer: clearable saturating cycle counter with terminal-count flag
//   clk, rst : clock and synchronous active-high reset
//   i_clr    : clear the count this cycle
//   o_tc     : count has reached TIMEOUT_CYC (holds until cleared)
module uart_frame_rx_gap_timer #(
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tc
);
  localparam int W = $clog2(TIMEOUT_CYC + 1);
  logic [W-1:0] r_cnt;
  assign o_tc = r_cnt == W'(TIMEOUT_CYC);
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_cnt <= '0;
    else if (!o_tc) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: parses A5 5A <slot> headers and streams FRAME_BYTES payload bytes to an SDRAM write port
//   rx_data/rx_valid      : bytes from the UART receiver
//   wr_full               : write FIFO cannot take a word; a payload byte arriving then aborts the frame
//   wr_data/wr_valid      : payload write words {8'h00, byte}
//   wr_load/wr_base_addr  : reload pulse and base address of the selected slot
//   cur_slot, byte_count  : slot and payload progress of the current/last frame
//   busy, frame_done, frame_err, frames_rx : status for the display/processor side
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = DEF_FRAME_BYTES,
  parameter logic [7:0]  SYNC0       = DEF_SYNC0,
  parameter logic [7:0]  SYNC1       = DEF_SYNC1,
  parameter int unsigned NUM_SLOTS   = DEF_NUM_SLOTS,
  parameter logic [22:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        wr_full,
  output logic [15:0] wr_data,
  output logic        wr_valid,
  output logic        wr_load,
  output logic [22:0] wr_base_addr,
  output logic [1:0]  cur_slot,
  output logic [18:0] byte_count,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err,
  output logic [7:0]  frames_rx
);
  state_t r_state, w_next;
  logic w_tc, w_load, w_wr, w_done, w_err;
  wire w_slot_ok = rx_data < 8'(NUM_SLOTS);
  wire w_last    = byte_count == 19'(FRAME_BYTES - 1);
  uart_frame_rx_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap (
    .clk   (clk),
    .rst   (rst),
    .i_clr (rx_valid || r_state == IDLE),
    .o_tc  (w_tc)
  );
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_wr   = 1'b0;
    w_done = 1'b0;
    w_err  = 1'b0;
    case (r_state)
      IDLE: w_next = (rx_valid && rx_data == SYNC0) ? HDR1 : IDLE;
      HDR1: if (rx_valid) w_next = rx_data == SYNC1 ? SLOT : rx_data == SYNC0 ? HDR1 : IDLE;
      SLOT: if (rx_valid) begin
        w_load = w_slot_ok;
        w_err  = !w_slot_ok;
        w_next = w_slot_ok ? PAYLOAD : IDLE;
      end
      PAYLOAD: if (rx_valid) begin
        w_wr   = !wr_full;
        w_err  = wr_full;
        w_done = !wr_full && w_last;
        w_next = (wr_full || w_last) ? IDLE : PAYLOAD;
      end
      default: w_next = IDLE;
    endcase
    // a byte arriving on the limit cycle wins, so the timeout only fires on a quiet cycle
    if (r_state != IDLE && !rx_valid && w_tc) begin
      w_err  = 1'b1;
      w_next = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_data      <= '0;
      wr_valid     <= 1'b0;
      wr_load      <= 1'b0;
      wr_base_addr <= BASE_ADDR;
      cur_slot     <= '0;
      byte_count   <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
      frames_rx    <= '0;
    end else begin
      wr_valid   <= w_wr;
      wr_load    <= w_load;
      frame_done <= w_done;
      frame_err  <= w_err;
      busy       <= w_next != IDLE;
      if (w_wr) wr_data <= {8'h00, rx_data};
      if (w_load) begin
        cur_slot     <= rx_data[1:0];
        wr_base_addr <= slot_base(rx_data[1:0], BASE_ADDR, FRAME_BYTES);
        byte_count   <= '0;
      end else if (w_wr) byte_count <= byte_count + 19'd1;
      if (w_done) frames_rx <= frames_rx + 8'd1;
    end
  end
endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: directed stimulus with an expected-event scoreboard checked by a monitor
module tb_uart_frame_rx;
  localparam int unsigned FB = 8;
  localparam int unsigned TO = 50;
  localparam logic [22:0] BASE = 23'h100000;
  localparam int EV_LOAD = 0, EV_WR = 1, EV_DONE = 2, EV_ERR = 3;
  typedef struct {int kind; logic [63:0] val;} ev_t;
  logic clk, rst, rx_valid, wr_full;
  logic [7:0] rx_data;
  logic [15:0] wr_data;
  logic wr_valid, wr_load, busy, frame_done, frame_err;
  logic [22:0] wr_base_addr;
  logic [1:0] cur_slot;
  logic [18:0] byte_count;
  logic [7:0] frames_rx;
  ev_t q[$];
  int n_checks = 0;
  int n_fail = 0;
  string kname[4] = '{"load", "write", "done", "err"};
  uart_frame_rx #(.FRAME_BYTES(FB), .TIMEOUT_CYC(TO), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .wr_full(wr_full),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_load(wr_load), .wr_base_addr(wr_base_addr),
    .cur_slot(cur_slot), .byte_count(byte_count), .busy(busy), .frame_done(frame_done),
    .frame_err(frame_err), .frames_rx(frames_rx)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic push(input int k, input logic [63:0] v);
    ev_t e;
    e.kind = k;
    e.val = v;
    q.push_back(e);
  endtask
  function automatic logic [22:0] base_of(input int slot);
    return BASE + 23'(slot * int'(FB));
  endfunction
  task automatic exp_load(input int slot);
    push(EV_LOAD, 64'({2'(slot), base_of(slot)}));
  endtask
  task automatic exp_wr(input int idx, input logic [7:0] d);
    push(EV_WR, 64'({19'(idx + 1), 8'h00, d}));
  endtask
  task automatic exp_done(input int n);
    push(EV_DONE, 64'({19'(FB), 8'(n)}));
  endtask
  task automatic see(input int k, input logic [63:0] v);
    ev_t e;
    if (q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected %s event: got %0h expected none", kname[k], v);
    end else begin
      e = q.pop_front();
      chk($sformatf("%s kind", kname[k]), 64'(k), 64'(e.kind));
      chk($sformatf("%s value", kname[k]), v, e.val);
    end
  endtask
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (wr_load && wr_valid) chk("load_and_write_together", 1, 0);
      if (wr_load) see(EV_LOAD, 64'({cur_slot, wr_base_addr}));
      if (wr_valid) see(EV_WR, 64'({byte_count, wr_data}));
      if (frame_done) see(EV_DONE, 64'({byte_count, frames_rx}));
      if (frame_err) see(EV_ERR, 64'(0));
    end
  endtask
  task automatic send(input logic [7:0] b, input logic full = 1'b0);
    rx_data = b;
    rx_valid = 1'b1;
    wr_full = full;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    wr_full = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic header(input logic [7:0] s);
    send(8'hA5);
    send(8'h5A);
    send(s);
  endtask
  task automatic full_frame(input int slot, input int n_after);
    exp_load(slot);
    for (int i = 0; i < int'(FB); i++) begin
      exp_wr(i, 8'(i + 1));
      if (i == int'(FB) - 1) exp_done(n_after);
    end
    header(8'(slot));
    for (int i = 0; i < int'(FB); i++) send(8'(i + 1));
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_base"}, 64'(wr_base_addr), 64'(BASE));
    chk({tag, "_slot"}, 64'(cur_slot), 0);
    chk({tag, "_count"}, 64'(byte_count), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_frames"}, 64'(frames_rx), 0);
    chk({tag, "_pulses"}, 64'({wr_valid, wr_load, frame_done, frame_err}), 0);
  endtask
  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    wr_full = 1'b0;
    fork monitor(); join_none
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset");
    // full frame into slot 2
    exp_load(2);
    for (int i = 0; i < int'(FB); i++) begin
      exp_wr(i, 8'(i));
      if (i == int'(FB) - 1) exp_done(1);
    end
    header(8'h02);
    for (int i = 0; i < int'(FB); i++) send(8'(i));
    chk("f1_busy", 64'(busy), 0);
    chk("f1_frames", 64'(frames_rx), 1);
    chk("f1_count", 64'(byte_count), 64'(FB));
    chk("f1_base", 64'(wr_base_addr), 64'(base_of(2)));
    // repeated sync then timeout mid-payload
    exp_load(1);
    for (int i = 0; i < 3; i++) exp_wr(i, 8'(8'h10 + i));
    push(EV_ERR, 0);
    send(8'hA5);
    send(8'hA5);
    send(8'h5A);
    send(8'h01);
    for (int i = 0; i < 3; i++) send(8'(8'h10 + i));
    idle(TO + 5);
    chk("to_slot", 64'(cur_slot), 1);
    chk("to_busy", 64'(busy), 0);
    chk("to_frames", 64'(frames_rx), 1);
    chk("to_count", 64'(byte_count), 3);
    // bad slot leaves slot/base alone; bad second sync is silent
    push(EV_ERR, 0);
    header(8'h07);
    idle(2);
    chk("badslot_base", 64'(wr_base_addr), 64'(base_of(1)));
    chk("badslot_slot", 64'(cur_slot), 1);
    send(8'hA5);
    chk("hdr1_busy", 64'(busy), 1);
    send(8'h13);
    idle(2);
    chk("badsync_busy", 64'(busy), 0);
    // write FIFO full aborts the frame
    exp_load(3);
    for (int i = 0; i < 5; i++) exp_wr(i, 8'(8'h20 + i));
    push(EV_ERR, 0);
    header(8'h03);
    for (int i = 0; i < 5; i++) send(8'(8'h20 + i));
    send(8'h77, 1'b1);
    chk("full_count", 64'(byte_count), 5);
    chk("full_busy", 64'(busy), 0);
    exp_load(0);
    header(8'h00);
    chk("restart_count", 64'(byte_count), 0);
    chk("restart_slot", 64'(cur_slot), 0);
    for (int i = 0; i < int'(FB); i++) begin
      exp_wr(i, 8'(8'h40 + i));
      if (i == int'(FB) - 1) exp_done(2);
    end
    for (int i = 0; i < int'(FB); i++) send(8'(8'h40 + i));
    chk("restart_frames", 64'(frames_rx), 2);
    // reset in the middle of a payload
    exp_load(1);
    for (int i = 0; i < 3; i++) exp_wr(i, 8'(8'h30 + i));
    header(8'h01);
    for (int i = 0; i < 3; i++) send(8'(8'h30 + i));
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk_reset_vals("midrst");
    full_frame(3, 1);
    chk("postrst_frames", 64'(frames_rx), 1);
    // back-to-back frames with sync bytes inside the payload; counter wraps
    for (int f = 0; f < 255; f++) begin
      exp_load(f % 4);
      for (int k = 0; k < int'(FB); k++) begin
        exp_wr(k, k == 0 ? 8'hA5 : k == 1 ? 8'h5A : 8'(f + k));
        if (k == int'(FB) - 1) exp_done((f + 2) % 256);
      end
      header(8'(f % 4));
      for (int k = 0; k < int'(FB); k++) send(k == 0 ? 8'hA5 : k == 1 ? 8'h5A : 8'(f + k));
    end
    chk("wrap_frames", 64'(frames_rx), 0);
    chk("wrap_busy", 64'(busy), 0);
    idle(5);
    chk("scoreboard_drained", 64'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
